// File: rtl/vx_scb_pkg.sv
// Shared types and sizing for the counting scoreboard.
//   CTR_W / WIS_W / NR_W / EX_W : derived field widths
//   ex_t                        : execution unit type
//   scb_req_t                   : one instruction as offered by the instruction buffer
//   popcount                    : slot-vector population count, used by the SCB_PERF_EN counters
package vx_scb_pkg;

    localparam int NUM_SLOTS     = 4;
    localparam int NUM_WIS       = 4;
    localparam int NUM_REGS      = 64;
    localparam int NUM_SRC       = 3;
    localparam int NUM_UNITS     = 4;
    localparam int MAX_PENDING   = 3;
    localparam bit R0_HARDWIRED  = 1'b1;
    localparam int DATAW         = 128;
    localparam int PERF_CTR_BITS = 32;

    localparam int CTR_W   = $clog2(MAX_PENDING + 1);
    localparam int WIS_W   = $clog2(NUM_WIS);
    localparam int NR_W    = $clog2(NUM_REGS);
    localparam int EX_W    = $clog2(NUM_UNITS);
    localparam int SLOT_CW = $clog2(NUM_SLOTS + 1);

    typedef enum logic [EX_W-1:0] {
        EX_ALU,
        EX_LSU,
        EX_FPU,
        EX_SFU
    } ex_t;

    typedef struct packed {
        logic [WIS_W-1:0]              wis;
        logic                          wb;
        logic [NR_W-1:0]               rd;
        logic [NUM_SRC-1:0][NR_W-1:0]  rs;
        ex_t                           ex;
        logic [DATAW-1:0]              data;
    } scb_req_t;

    function automatic logic [SLOT_CW-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [SLOT_CW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + SLOT_CW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/vx_counting_scoreboard_if.sv
// Flattened per-slot buses between instruction buffer, writeback and dispatch.
//   ibuf_*  : instruction offer / accept
//   wb_*    : writeback retire beats
//   scb_*   : dispatch handshake
//   err_underflow : sticky per-slot retire-without-pending flag
// master = environment side, slave = scoreboard side.
interface vx_counting_scoreboard_if;
    import vx_scb_pkg::*;

    logic [NUM_SLOTS-1:0]              ibuf_valid;
    logic [NUM_SLOTS-1:0]              ibuf_ready;
    logic [NUM_SLOTS*WIS_W-1:0]        ibuf_wis;
    logic [NUM_SLOTS-1:0]              ibuf_wb;
    logic [NUM_SLOTS*NR_W-1:0]         ibuf_rd;
    logic [NUM_SLOTS*NUM_SRC*NR_W-1:0] ibuf_rs;
    logic [NUM_SLOTS*EX_W-1:0]         ibuf_ex;
    logic [NUM_SLOTS*DATAW-1:0]        ibuf_data;
    logic [NUM_SLOTS-1:0]              wb_valid;
    logic [NUM_SLOTS-1:0]              wb_eop;
    logic [NUM_SLOTS*WIS_W-1:0]        wb_wis;
    logic [NUM_SLOTS*NR_W-1:0]         wb_rd;
    logic [NUM_SLOTS-1:0]              scb_valid;
    logic [NUM_SLOTS*DATAW-1:0]        scb_data;
    logic [NUM_SLOTS-1:0]              scb_ready;
    logic [NUM_SLOTS-1:0]              err_underflow;

    modport master (
        output ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs, ibuf_ex, ibuf_data,
        output wb_valid, wb_eop, wb_wis, wb_rd, scb_ready,
        input  ibuf_ready, scb_valid, scb_data, err_underflow
    );

    modport slave (
        input  ibuf_valid, ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs, ibuf_ex, ibuf_data,
        input  wb_valid, wb_eop, wb_wis, wb_rd, scb_ready,
        output ibuf_ready, scb_valid, scb_data, err_underflow
    );

endinterface

// File: rtl/vx_scb_slot.sv
// One issue slot: per-register pending-write counters, RAW/WAW hazard check
// and a 2-entry registered skid stage toward dispatch.
//   clk, reset              : clock, async active-high reset
//   ibuf_valid/ready/req    : instruction offer and accept
//   wb_valid/eop/wis/rd     : writeback beats (eop beat retires one pending write)
//   scb_valid/data/ready    : dispatch handshake
//   err_underflow           : sticky retire-with-zero-count flag
//   waw_merge               : accept onto an already-pending register (SCB_PERF_EN only)
module vx_scb_slot
    import vx_scb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ibuf_valid,
    output logic             ibuf_ready,
    input  scb_req_t         ibuf_req,
    input  logic             wb_valid,
    input  logic             wb_eop,
    input  logic [WIS_W-1:0] wb_wis,
    input  logic [NR_W-1:0]  wb_rd,
    output logic             scb_valid,
    output logic [DATAW-1:0] scb_data,
    input  logic             scb_ready,
    output logic             err_underflow
`ifdef SCB_PERF_EN
    ,
    output logic             waw_merge
`endif
);

    logic [CTR_W-1:0] cnt    [NUM_WIS][NUM_REGS];
    ex_t              unit_q [NUM_WIS][NUM_REGS];

    logic             head_v, tail_v;
    logic [DATAW-1:0] head_d, tail_d;

    logic [CTR_W-1:0] rd_cnt, ret_cnt;
    ex_t              rd_unit;
    logic             src_busy, rd_block;
    logic             push, pop, acc_fire, ret_fire, same_reg;

    assign rd_cnt  = cnt[ibuf_req.wis][ibuf_req.rd];
    assign rd_unit = unit_q[ibuf_req.wis][ibuf_req.rd];
    assign ret_cnt = cnt[wb_wis][wb_rd];

    always_comb begin
        src_busy = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (cnt[ibuf_req.wis][ibuf_req.rs[s]] != '0 &&
                !(R0_HARDWIRED && ibuf_req.rs[s] == '0)) begin
                src_busy = 1'b1;
            end
        end
    end

    // Several writes may be in flight to one register only if they go to the
    // same in-order unit, so they retire in issue order.
    assign rd_block = ibuf_req.wb && rd_cnt != '0 &&
                      (rd_unit != ibuf_req.ex || rd_cnt == CTR_W'(MAX_PENDING));

    assign ibuf_ready = !tail_v && !src_busy && !rd_block;

    assign push     = ibuf_valid && ibuf_ready;
    assign pop      = head_v && scb_ready;
    assign acc_fire = push && ibuf_req.wb && !(R0_HARDWIRED && ibuf_req.rd == '0);
    // r0 writebacks are dropped when r0 is hardwired: nothing was ever counted
    // for it, so they must not trip the underflow flag.
    assign ret_fire = wb_valid && wb_eop && !(R0_HARDWIRED && wb_rd == '0);
    assign same_reg = ibuf_req.wis == wb_wis && ibuf_req.rd == wb_rd;

`ifdef SCB_PERF_EN
    assign waw_merge = acc_fire && rd_cnt != '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WIS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt[w][r]    <= '0;
                    unit_q[w][r] <= EX_ALU;
                end
            end
            err_underflow <= 1'b0;
        end else begin
            // A matching accept and retire cancel; a retire at zero saturates
            // and only raises the error, so a matching accept still counts.
            if (ret_fire) begin
                if (ret_cnt == '0) begin
                    err_underflow <= 1'b1;
                end else if (!(acc_fire && same_reg)) begin
                    cnt[wb_wis][wb_rd] <= ret_cnt - 1'b1;
                end
            end
            if (acc_fire) begin
                unit_q[ibuf_req.wis][ibuf_req.rd] <= ibuf_req.ex;
                if (!(ret_fire && same_reg && ret_cnt != '0)) begin
                    cnt[ibuf_req.wis][ibuf_req.rd] <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Head register drives dispatch directly; tail only fills while head is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
            head_d <= '0;
            tail_d <= '0;
        end else if (pop) begin
            if (tail_v) begin
                head_d <= tail_d;
                tail_v <= 1'b0;
            end else if (push) begin
                head_d <= ibuf_req.data;
            end else begin
                head_v <= 1'b0;
            end
        end else if (push) begin
            if (!head_v) begin
                head_v <= 1'b1;
                head_d <= ibuf_req.data;
            end else begin
                tail_v <= 1'b1;
                tail_d <= ibuf_req.data;
            end
        end
    end

    assign scb_valid = head_v;
    assign scb_data  = head_d;

endmodule

// File: rtl/vx_counting_scoreboard.sv
// Counting register scoreboard: NUM_SLOTS independent vx_scb_slot instances.
//   clk, reset : clock, async active-high reset
//   bus        : vx_counting_scoreboard_if.slave (instruction, writeback, dispatch)
// Build option SCB_PERF_EN adds:
//   perf_stalls     : accumulated count of slot-cycles with ibuf_valid && !ibuf_ready
//   perf_waw_merges : accepts landing on an already-pending register
module vx_counting_scoreboard
    import vx_scb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    vx_counting_scoreboard_if.slave  bus
`ifdef SCB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_stalls,
    output logic [PERF_CTR_BITS-1:0] perf_waw_merges
`endif
);

`ifdef SCB_PERF_EN
    logic [NUM_SLOTS-1:0] waw_vec;
`endif

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        scb_req_t req;

        always_comb begin
            req.wis  = bus.ibuf_wis[s*WIS_W +: WIS_W];
            req.wb   = bus.ibuf_wb[s];
            req.rd   = bus.ibuf_rd[s*NR_W +: NR_W];
            for (int k = 0; k < NUM_SRC; k++) begin
                req.rs[k] = bus.ibuf_rs[(s*NUM_SRC + k)*NR_W +: NR_W];
            end
            req.ex   = ex_t'(bus.ibuf_ex[s*EX_W +: EX_W]);
            req.data = bus.ibuf_data[s*DATAW +: DATAW];
        end

        vx_scb_slot u_slot (
            .clk           (clk),
            .reset         (reset),
            .ibuf_valid    (bus.ibuf_valid[s]),
            .ibuf_ready    (bus.ibuf_ready[s]),
            .ibuf_req      (req),
            .wb_valid      (bus.wb_valid[s]),
            .wb_eop        (bus.wb_eop[s]),
            .wb_wis        (bus.wb_wis[s*WIS_W +: WIS_W]),
            .wb_rd         (bus.wb_rd[s*NR_W +: NR_W]),
            .scb_valid     (bus.scb_valid[s]),
            .scb_data      (bus.scb_data[s*DATAW +: DATAW]),
            .scb_ready     (bus.scb_ready[s]),
            .err_underflow (bus.err_underflow[s])
`ifdef SCB_PERF_EN
            ,
            .waw_merge     (waw_vec[s])
`endif
        );
    end

`ifdef SCB_PERF_EN
    // Stall popcount is staged one cycle to keep the reduction off the adder path.
    logic [SLOT_CW-1:0] stall_pop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_pop_q     <= '0;
            perf_stalls     <= '0;
            perf_waw_merges <= '0;
        end else begin
            stall_pop_q     <= popcount(bus.ibuf_valid & ~bus.ibuf_ready);
            perf_stalls     <= perf_stalls + PERF_CTR_BITS'(stall_pop_q);
            perf_waw_merges <= perf_waw_merges + PERF_CTR_BITS'(popcount(waw_vec));
        end
    end
`endif

endmodule

// File: tb/tb_vx_counting_scoreboard.sv
module tb_vx_counting_scoreboard;
    import vx_scb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_counting_scoreboard_if bus();

`ifdef SCB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls, perf_waw_merges;
`endif

    vx_counting_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SCB_PERF_EN
        ,
        .perf_stalls     (perf_stalls),
        .perf_waw_merges (perf_waw_merges)
`endif
    );

    typedef struct {
        bit             valid;
        bit [WIS_W-1:0] wis;
        bit             wb;
        bit [NR_W-1:0]  rd, rs1, rs2, rs3;
        bit [EX_W-1:0]  ex;
        bit [7:0]       d;
        bit             wbv, eop;
        bit [WIS_W-1:0] wbwis;
        bit [NR_W-1:0]  wbrd;
        bit             exp_rdy, exp_sv;
        bit [7:0]       exp_d;
        bit             exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(int valid, int wis, int wb, int rd, int rs1, int rs2, int rs3,
                                int ex, int d, int wbv, int eop, int wbwis, int wbrd,
                                int rdy, int sv, int ed, int err);
        vec_t r;
        r.valid = 1'(valid);  r.wis = WIS_W'(wis);  r.wb = 1'(wb);  r.rd = NR_W'(rd);
        r.rs1 = NR_W'(rs1);   r.rs2 = NR_W'(rs2);   r.rs3 = NR_W'(rs3);
        r.ex = EX_W'(ex);     r.d = 8'(d);
        r.wbv = 1'(wbv);      r.eop = 1'(eop);      r.wbwis = WIS_W'(wbwis);  r.wbrd = NR_W'(wbrd);
        r.exp_rdy = 1'(rdy);  r.exp_sv = 1'(sv);    r.exp_d = 8'(ed);         r.exp_err = 1'(err);
        return r;
    endfunction

    function automatic void add(int valid, int wis, int wb, int rd, int rs1, int rs2, int rs3,
                                int ex, int d, int wbv, int eop, int wbwis, int wbrd,
                                int rdy, int sv, int ed, int err);
        vecs.push_back(mk(valid, wis, wb, rd, rs1, rs2, rs3, ex, d, wbv, eop, wbwis, wbrd,
                          rdy, sv, ed, err));
    endfunction

    task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slot 0 gets the vector, the other slots stay idle.
    task automatic drive(input vec_t r, input logic srdy);
        bus.ibuf_valid = '0;  bus.ibuf_valid[0] = r.valid;
        bus.ibuf_wis   = '0;  bus.ibuf_wis[WIS_W-1:0] = r.wis;
        bus.ibuf_wb    = '0;  bus.ibuf_wb[0] = r.wb;
        bus.ibuf_rd    = '0;  bus.ibuf_rd[NR_W-1:0] = r.rd;
        bus.ibuf_rs    = '0;
        bus.ibuf_rs[0 +: NR_W]      = r.rs1;
        bus.ibuf_rs[NR_W +: NR_W]   = r.rs2;
        bus.ibuf_rs[2*NR_W +: NR_W] = r.rs3;
        bus.ibuf_ex    = '0;  bus.ibuf_ex[EX_W-1:0] = r.ex;
        bus.ibuf_data  = '0;  bus.ibuf_data[DATAW-1:0] = {(DATAW/8){r.d}};
        bus.wb_valid   = '0;  bus.wb_valid[0] = r.wbv;
        bus.wb_eop     = '0;  bus.wb_eop[0] = r.eop;
        bus.wb_wis     = '0;  bus.wb_wis[WIS_W-1:0] = r.wbwis;
        bus.wb_rd      = '0;  bus.wb_rd[NR_W-1:0] = r.wbrd;
        bus.scb_ready  = '1;  bus.scb_ready[0] = srdy;
    endtask

    task automatic check_row(input string tag, input vec_t r);
        chk({tag, " ibuf_ready"}, DATAW'(bus.ibuf_ready[0]), DATAW'(r.exp_rdy));
        chk({tag, " scb_valid"}, DATAW'(bus.scb_valid[0]), DATAW'(r.exp_sv));
        if (r.exp_sv) chk({tag, " scb_data"}, bus.scb_data[DATAW-1:0], {(DATAW/8){r.exp_d}});
        chk({tag, " err_underflow"}, DATAW'(bus.err_underflow[0]), DATAW'(r.exp_err));
    endtask

    task automatic step(input string tag, input vec_t r, input logic srdy);
        @(negedge clk);
        drive(r, srdy);
        #1;
        check_row(tag, r);
    endtask

    vec_t idle;

    initial begin
        //   vl wis wb rd rs1 rs2 rs3 ex  d      wbv eop wwis wrd  rdy sv ed     err
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 0);  // idle after reset
        add(1, 0, 1, 5, 0, 0, 0, 0, 'h11,  0, 0, 0, 0,  1, 0, 'h00, 0);  // RAW: write r5
        add(1, 0, 0, 0, 5, 0, 0, 0, 'h22,  0, 0, 0, 0,  0, 1, 'h11, 0);  // read r5 stalls
        add(1, 0, 0, 0, 5, 0, 0, 0, 'h22,  1, 1, 0, 5,  0, 0, 'h00, 0);  // retire, still stalled
        add(1, 0, 0, 0, 5, 0, 0, 0, 'h22,  0, 0, 0, 0,  1, 0, 'h00, 0);  // unblocked
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 1, 'h22, 0);
        add(1, 0, 1, 7, 0, 0, 0, 0, 'h31,  0, 0, 0, 0,  1, 0, 'h00, 0);  // WAW r7 x3 on ALU
        add(1, 0, 1, 7, 0, 0, 0, 0, 'h32,  0, 0, 0, 0,  1, 1, 'h31, 0);
        add(1, 0, 1, 7, 0, 0, 0, 0, 'h33,  0, 0, 0, 0,  1, 1, 'h32, 0);
        add(1, 0, 1, 7, 0, 0, 0, 0, 'h34,  0, 0, 0, 0,  0, 1, 'h33, 0);  // 4th blocked
        add(1, 0, 1, 7, 0, 0, 0, 1, 'h35,  0, 0, 0, 0,  0, 0, 'h00, 0);  // LSU blocked
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  1, 1, 0, 7,  1, 0, 'h00, 0);  // 3 -> 2
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  1, 1, 0, 7,  1, 0, 'h00, 0);  // 2 -> 1
        add(1, 0, 1, 7, 0, 0, 0, 1, 'h36,  1, 1, 0, 7,  0, 0, 'h00, 0);  // LSU still blocked, 1 -> 0
        add(1, 0, 1, 7, 0, 0, 0, 1, 'h36,  0, 0, 0, 0,  1, 0, 'h00, 0);  // LSU accepted
        add(0, 0, 1, 7, 0, 0, 0, 0, 'h00,  1, 1, 0, 7,  0, 1, 'h36, 0);  // ALU now blocked
        add(0, 0, 0, 0, 7, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 0);  // r7 free
        add(1, 0, 1, 9, 0, 0, 0, 0, 'h41,  0, 0, 0, 0,  1, 0, 'h00, 0);  // r9 cnt 1
        add(1, 0, 1, 9, 0, 0, 0, 0, 'h42,  1, 1, 0, 9,  1, 1, 'h41, 0);  // accept + retire
        add(0, 0, 0, 0, 0, 0, 9, 0, 'h00,  0, 0, 0, 0,  0, 1, 'h42, 0);  // still pending
        add(0, 0, 0, 0, 0, 9, 0, 0, 'h00,  1, 0, 0, 9,  0, 0, 'h00, 0);  // non-eop beat
        add(0, 0, 0, 0, 0, 0, 9, 0, 'h00,  1, 1, 0, 9,  0, 0, 'h00, 0);  // eop 1 -> 0
        add(0, 0, 0, 0, 9, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 'h51,  0, 0, 0, 0,  1, 0, 'h00, 0);  // write r0
        add(1, 0, 1, 0, 0, 0, 0, 2, 'h52,  0, 0, 0, 0,  1, 1, 'h51, 0);  // r0 never pending
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 1, 'h52, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  1, 1, 0, 3,  1, 0, 'h00, 0);  // underflow r3
        add(0, 0, 0, 0, 3, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 1);  // r3 stays 0
        add(0, 0, 0, 0, 0, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 1);
        add(1, 1, 1, 5, 0, 0, 0, 0, 'h61,  0, 0, 0, 0,  1, 0, 'h00, 1);  // warp 1 writes r5
        add(0, 0, 0, 0, 5, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 1, 'h61, 1);  // warp 0 unaffected
        add(0, 1, 0, 0, 5, 0, 0, 0, 'h00,  1, 1, 1, 5,  0, 0, 'h00, 1);  // warp 1 stalls
        add(0, 1, 0, 0, 5, 0, 0, 0, 'h00,  0, 0, 0, 0,  1, 0, 'h00, 1);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(idle, 1'b1);
        reset = 1'b1;
        #12;
        chk("reset scb_valid", DATAW'(bus.scb_valid), '0);
        chk("reset err_underflow", DATAW'(bus.err_underflow), '0);
        chk("reset ibuf_ready", DATAW'(bus.ibuf_ready), DATAW'({NUM_SLOTS{1'b1}}));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i), vecs[i], 1'b1);
        end

        chk("other slots err_underflow", DATAW'(bus.err_underflow[NUM_SLOTS-1:1]), '0);

        // Backpressure: two entries fill the skid, third offer held, then drain in order.
        step("bp0", mk(1, 0, 0, 0, 0, 0, 0, 0, 'h71, 0, 0, 0, 0, 1, 0, 'h00, 1), 1'b0);
        step("bp1", mk(1, 0, 0, 0, 0, 0, 0, 0, 'h72, 0, 0, 0, 0, 1, 1, 'h71, 1), 1'b0);
        step("bp2", mk(1, 0, 0, 0, 0, 0, 0, 0, 'h73, 0, 0, 0, 0, 0, 1, 'h71, 1), 1'b0);
        step("bp3", mk(1, 0, 0, 0, 0, 0, 0, 0, 'h73, 0, 0, 0, 0, 0, 1, 'h71, 1), 1'b0);
        step("bp4", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 1, 'h71, 1), 1'b1);
        step("bp5", mk(1, 0, 0, 0, 0, 0, 0, 0, 'h73, 0, 0, 0, 0, 1, 1, 'h72, 1), 1'b1);
        step("bp6", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 1, 'h73, 1), 1'b1);
        step("bp7", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 1), 1'b1);

        // Async reset with two buffered entries and r10 pending.
        step("rs0", mk(1, 0, 1, 10, 0, 0, 0, 0, 'h81, 0, 0, 0, 0, 1, 0, 'h00, 1), 1'b0);
        step("rs1", mk(1, 0, 1, 10, 0, 0, 0, 0, 'h82, 0, 0, 0, 0, 1, 1, 'h81, 1), 1'b0);
        step("rs2", mk(0, 0, 0, 0, 10, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 1, 'h81, 1), 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_row("rs_async", mk(0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #1;
        reset = 1'b0;
        step("rs_after", mk(0, 0, 0, 0, 10, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 0), 1'b1);
        step("rs_after2", mk(0, 0, 0, 0, 10, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
